// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter UART path: ASCII constants, formatter
// state encoding and frame length.
package voltmeter_pkg;

  localparam logic [7:0] CHAR_C     = 8'h43;
  localparam logic [7:0] CHAR_H     = 8'h48;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_DOT   = 8'h2E;
  localparam logic [7:0] CHAR_V     = 8'h56;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // "CH00: 0.000 V" is 13 bytes, followed by either CR+LF or LF alone.
  function automatic logic [3:0] frame_len(input logic term_crlf);
    return term_crlf ? 4'd15 : 4'd14;
  endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Maps one BCD nibble to its ASCII digit; non-BCD codes render as '?'.
module bcd_to_ascii
  import voltmeter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digit lookup with '?' for codes 10..15
  always_comb begin
    if (nibble <= 4'd9) begin
      ascii = CHAR_ZERO + {4'd0, nibble};
    end else begin
      ascii = CHAR_QMARK;
    end
  end

endmodule

// File: rtl/uart_frame_formatter.sv
// Turns one voltage sample into an ASCII line "CHnn: d.ddd V" pushed byte by
// byte into the UART TX FIFO, pacing itself on tx_full.
module uart_frame_formatter
  import voltmeter_pkg::*;
#(
  parameter bit TERM_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic [3:0]  channel,
  input  logic        sample_valid,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy,
  output logic [7:0]  dropped
);

  localparam logic [3:0] FRAME_LEN = frame_len(TERM_CRLF);

  state_t      state_r;
  logic [3:0]  idx_r;
  logic [15:0] in_r;
  logic [3:0]  chan_r;
  logic [3:0]  tens_s;
  logic [3:0]  units_s;
  logic [3:0]  nib_s;
  logic [7:0]  nib_ascii_s;
  logic [7:0]  byte_s;

  // Channel split into two decimal digits; out-of-range channels feed a non-BCD code so they print '?'
  always_comb begin
    tens_s  = 4'hF;
    units_s = 4'hF;
    if (chan_r <= 4'd9) begin
      tens_s  = 4'd0;
      units_s = chan_r;
    end else if (chan_r <= 4'd12) begin
      tens_s  = 4'd1;
      units_s = chan_r - 4'd10;
    end else begin
      tens_s  = 4'hF;
      units_s = 4'hF;
    end
  end

  // Nibble feeding the shared digit converter for the current byte position
  always_comb begin
    nib_s = 4'd0;
    case (idx_r)
      4'd2:    nib_s = tens_s;
      4'd3:    nib_s = units_s;
      4'd6:    nib_s = in_r[15:12];
      4'd8:    nib_s = in_r[11:8];
      4'd9:    nib_s = in_r[7:4];
      4'd10:   nib_s = in_r[3:0];
      default: nib_s = 4'd0;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .nibble (nib_s),
    .ascii  (nib_ascii_s)
  );

  // Byte to write at the current index
  always_comb begin
    byte_s = 8'h00;
    case (idx_r)
      4'd0:                     byte_s = CHAR_C;
      4'd1:                     byte_s = CHAR_H;
      4'd2, 4'd3, 4'd6:         byte_s = nib_ascii_s;
      4'd4:                     byte_s = CHAR_COLON;
      4'd5, 4'd11:              byte_s = CHAR_SPACE;
      4'd7:                     byte_s = CHAR_DOT;
      4'd8, 4'd9, 4'd10:        byte_s = nib_ascii_s;
      4'd12:                    byte_s = CHAR_V;
      4'd13:                    byte_s = TERM_CRLF ? CHAR_CR : CHAR_LF;
      4'd14:                    byte_s = CHAR_LF;
      default:                  byte_s = 8'h00;
    endcase
  end

  // Frame sequencer, FIFO write port and drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      in_r    <= 16'h0000;
      chan_r  <= 4'd0;
      w_data  <= 8'h00;
      wr_uart <= 1'b0;
      busy    <= 1'b0;
      dropped <= 8'h00;
    end else begin
      if (sample_valid && (state_r != IDLE) && (dropped != 8'hFF)) begin
        dropped <= dropped + 8'd1;
      end
      case (state_r)
        IDLE: begin
          wr_uart <= 1'b0;
          idx_r   <= 4'd0;
          if (sample_valid) begin
            state_r <= SEND;
            busy    <= 1'b1;
            in_r    <= in;
            chan_r  <= channel;
            // The leading 'C' is constant, so it can go out on the capture edge
            if (!tx_full) begin
              w_data  <= CHAR_C;
              wr_uart <= 1'b1;
              idx_r   <= 4'd1;
            end
          end
        end
        SEND: begin
          if (idx_r == FRAME_LEN) begin
            state_r <= DONE;
            wr_uart <= 1'b0;
          end else if (!tx_full) begin
            w_data  <= byte_s;
            wr_uart <= 1'b1;
            idx_r   <= idx_r + 4'd1;
          end else begin
            wr_uart <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          wr_uart <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          wr_uart <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_frame_formatter.md
UART_FRAME_FORMATTER -- requirements
Module: uart_frame_formatter

Interface
REQ-001 SHALL have parameter TERM_CRLF, default 1, selecting the terminator: 1 = CR+LF (15-byte frame), 0 = LF only (14-byte frame).
REQ-002 SHALL have port clk, input, 1, the single clock (clk100Mhz domain); all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port in, input, 16, four BCD digits of a voltage reading; in[15:12] is the integer volt and in[11:0] is three fractional digits.
REQ-005 SHALL have port channel, input, 4, the source channel number, valid range 0..12.
REQ-006 SHALL have port sample_valid, input, 1, a one-cycle strobe qualifying in and channel.
REQ-007 SHALL have port tx_full, input, 1, the UART TX FIFO full flag.
REQ-008 SHALL have port w_data, output, 8, the ASCII byte to the UART FIFO.
REQ-009 SHALL have port wr_uart, output, 1, the one-cycle FIFO write strobe qualifying w_data.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port dropped, output, 8, a saturating count of samples rejected while busy.

Function
REQ-012 Frame byte order SHALL be: 'C','H',chan_tens,chan_units,':',' ',d3,'.',d2,d1,d0,' ','V',[CR if TERM_CRLF],LF.
REQ-013 Channel SHALL be rendered as two decimal digits (0..12 -> "00".."12"); a channel of 13..15 SHALL render as "??".
REQ-014 Each BCD nibble 0..9 SHALL map to 0x30+nibble; nibbles 10..15 SHALL map to '?' (0x3F).
REQ-015 FSM states SHALL be IDLE, SEND and DONE.
- IDLE -> SEND on sample_valid: capture in and channel, set busy, clear the byte index.
- SEND -> DONE after the last byte is written.
- DONE -> IDLE in one cycle, clearing busy.
REQ-016 In SEND, wr_uart SHALL be asserted only in cycles where tx_full==0, writing one byte per cycle and incrementing the index; when tx_full==1, wr_uart SHALL be 0 and the index SHALL hold.
REQ-017 w_data SHALL be valid in the same cycle as wr_uart (registered outputs, driven together).
REQ-018 Latency: with sample_valid at cycle N and tx_full=0, the first wr_uart SHALL occur at N+1 and the last at N+FRAME_LEN.
REQ-019 busy SHALL rise at N+1 and fall at N+FRAME_LEN+2; the next frame SHALL NOT start before busy falls.
REQ-020 sample_valid while busy SHALL be ignored: captured data unchanged, dropped incremented by 1, saturating at 255.
REQ-021 sample_valid in the DONE cycle SHALL count as busy (dropped increments).
REQ-022 Captured data SHALL remain stable for the whole frame, independent of changes on in or channel.
REQ-023 No byte SHALL be skipped or duplicated under any tx_full pattern, including tx_full toggling every cycle.

Reset
REQ-024 On rst low, the state SHALL become IDLE immediately and the outputs SHALL be w_data=0x00, wr_uart=0, busy=0, dropped=0, index=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no wr_uart SHALL occur after rst falls, and after release the block SHALL await a new sample_valid.
REQ-026 Reset release SHALL take effect on the first clk edge with rst high; the captured register contents are don't-care.

Structure
REQ-027 The ASCII constants (CHAR_C, CHAR_H, CHAR_COLON, CHAR_SPACE, CHAR_DOT, CHAR_V, CHAR_CR, CHAR_LF, CHAR_QMARK), the state encoding, and the FRAME_LEN computation SHALL live in the shared package voltmeter_pkg.
REQ-028 Nibble-to-ASCII mapping SHALL be one combinational sub-module, bcd_to_ascii, instantiated per digit or muxed by index.
REQ-029 Target size SHALL be 120-400 RTL lines; there SHALL be no FIFO inside the block (the UART FIFO provides buffering).

Verification
REQ-030 Scenario 1: in=16'h3141, channel=7, one sample_valid, tx_full=0, TERM_CRLF=1 -> 15 consecutive writes "CH07: 3.141 V\r\n", busy high for 16 cycles, dropped=0.
REQ-031 Scenario 2: tx_full held 1 for 5 cycles after byte 4, then tx_full toggled on/off -> byte stream identical to Scenario 1, no write while tx_full=1.
REQ-032 Scenario 3: in=16'hA0F9, channel=14 -> "CH??: ?.0?9 V\r\n".
REQ-033 Scenario 4: three sample_valid pulses during one frame plus one in the DONE cycle -> dropped=4, a single frame output with the first sample's data; 260 rejected pulses -> dropped=255.
REQ-034 Scenario 5: rst asserted after byte 6 -> wr_uart=0 and all outputs reset immediately; a new sample after release -> complete fresh frame.
REQ-035 Scenario 6: TERM_CRLF=0, channel=12, in=16'h0000 -> 14 bytes "CH12: 0.000 V\n", busy high for 15 cycles.
